// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave running in the system clock domain.
// Synchronises the SPI pins, detects SCLK edges for any CPOL/CPHA mode and
// exchanges DATA_WIDTH-bit words (MSB first), back-to-back within a frame.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sclk, cs_n, mosi    asynchronous SPI pins from the master
//   miso, miso_oe       slave data out and its pad output enable
//   tx_data/valid/ready TX holding register handshake
//   rx_data/valid/ready received word handshake
//   rx_overrun          pulse: completed word dropped, previous one still pending
//   frame_err           pulse: cs_n released in the middle of a word
//   busy                a frame is being served
module spi_slave_sync #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic IDLE_LVL = 1'(CPOL);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic [SYNC_STAGES-1:0]  warm;
    logic                    sclk_prev;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    word_done;
    logic [DATA_WIDTH-2:0]   rx_sr;
    logic [DATA_WIDTH-1:0]   tx_sr;
    logic [DATA_WIDTH-1:0]   tx_hold;

    logic                    sclk_s, cs_n_s, mosi_s, warm_c;
    logic                    leading_c, trailing_c, sample_c, shift_c;
    logic                    start_c, run_c, word_c, act_nxt_c;
    logic                    reload_c, take_c, load_c, shift_ok_c;
    logic [DATA_WIDTH-1:0]   rx_word_c;
    logic [DATA_WIDTH-1:0]   tx_sr_nxt_c;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    // warm marks that the reset fill of the synchronisers has been flushed,
    // so cs_n_s reflects the pin and a frame open across reset stays ignored.
    assign warm_c = warm[SYNC_STAGES-1];

    // Pin synchronisers and previous-SCLK register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            warm      <= '0;
            sclk_prev <= IDLE_LVL;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
        end
    end

    // Edge classification, handshake qualifiers and next TX shift value.
    always_comb begin
        leading_c   = (sclk_prev == IDLE_LVL) && (sclk_s != IDLE_LVL);
        trailing_c  = (sclk_prev != IDLE_LVL) && (sclk_s == IDLE_LVL);
        sample_c    = (CPHA == 0) ? leading_c : trailing_c;
        shift_c     = (CPHA == 0) ? trailing_c : leading_c;
        start_c     = (state == IDLE) && !cs_n_s;
        run_c       = (state == ACTIVE) && !cs_n_s;
        act_nxt_c   = start_c || run_c;
        word_c      = run_c && sample_c && (bit_cnt == LAST_BIT);
        rx_word_c   = {rx_sr, mosi_s};
        // CPHA=1 presents the next MSB right at the word-complete sample edge;
        // CPHA=0 waits for the following shift edge.
        reload_c    = start_c ||
                      ((CPHA == 0) ? (run_c && shift_c && word_done) : word_c);
        // The first shift edge of a CPHA=1 word would skip the MSB.
        shift_ok_c  = run_c && shift_c &&
                      ((CPHA == 0) ? !word_done : (bit_cnt != '0));
        take_c      = reload_c && !tx_ready;
        load_c      = tx_valid && tx_ready;
        tx_sr_nxt_c = tx_sr;
        if (reload_c) begin
            tx_sr_nxt_c = tx_ready ? '0 : tx_hold;
        end else if (shift_ok_c) begin
            tx_sr_nxt_c = tx_sr << 1;
        end
    end

    // Frame FSM, bit counter, shift registers and both handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_IDLE;
            bit_cnt    <= '0;
            word_done  <= 1'b0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            tx_hold    <= '0;
            tx_ready   <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_sr      <= tx_sr_nxt_c;
            miso       <= act_nxt_c & tx_sr_nxt_c[DATA_WIDTH-1];
            miso_oe    <= act_nxt_c;
            busy       <= act_nxt_c;

            // A new word takes priority over emptying: tx_ready stays low.
            if (load_c) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end else if (take_c) begin
                tx_ready <= 1'b1;
            end

            case (state)
                WAIT_IDLE: begin
                    if (warm_c && cs_n_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!cs_n_s) begin
                        state     <= ACTIVE;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_n_s) begin
                        state     <= IDLE;
                        frame_err <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                    end else if (sample_c) begin
                        rx_sr <= rx_word_c[DATA_WIDTH-2:0];
                        if (word_c) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (shift_c) begin
                        word_done <= 1'b0;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase

            // Completed word lands unless an unread one is still held.
            if (word_c) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_word_c;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: four slaves (one per CPOL/CPHA mode) share cs_n, mosi and
// the TX/RX handshakes; each has its own SCLK line driven by a master model.
module tb_spi_slave_sync;

    localparam int unsigned W = 8;
    localparam int HALF = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     sclk_v;
    logic           cs_n;
    logic           mosi;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           rx_ready;
    logic [3:0]     miso_v, miso_oe_v, tx_ready_v, rx_valid_v;
    logic [3:0]     rx_overrun_v, frame_err_v, busy_v;
    logic [W-1:0]   rx_data_v [4];

    int checks;
    int errors;
    int ovr_cnt;
    int ferr_cnt;

    typedef struct {
        int         mode;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_sync #(
            .DATA_WIDTH (W),
            .CPOL       (g / 2),
            .CPHA       (g % 2),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .sclk      (sclk_v[g]),
            .cs_n      (cs_n),
            .mosi      (mosi),
            .miso      (miso_v[g]),
            .miso_oe   (miso_oe_v[g]),
            .tx_data   (tx_data),
            .tx_valid  (tx_valid),
            .tx_ready  (tx_ready_v[g]),
            .rx_data   (rx_data_v[g]),
            .rx_valid  (rx_valid_v[g]),
            .rx_ready  (rx_ready),
            .rx_overrun(rx_overrun_v[g]),
            .frame_err (frame_err_v[g]),
            .busy      (busy_v[g])
        );
    end

    // Pulse counters for the mode-0 slave.
    always @(posedge clk) begin
        if (rx_overrun_v[0]) ovr_cnt <= ovr_cnt + 1;
        if (frame_err_v[0])  ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // Half SCLK period after a sample edge; optionally raise rx_ready only in
    // the clock where the slave registers that edge (3 clocks after the pin).
    task automatic wait_sample(input bit rdy_pulse);
        if (rdy_pulse) begin
            tick(2);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        tick(HALF);
    endtask

    // Master clocks n bits of mo (MSB first) in mode m and captures miso.
    task automatic spi_bits(input int m, input logic [7:0] mo, input int n,
                            input bit rdy_last, output logic [7:0] mi);
        logic cpol;
        int   b;
        bit   last;
        cpol = ((m / 2) != 0);
        mi   = '0;
        for (int i = 0; i < n; i++) begin
            b    = 7 - i;
            last = rdy_last && (i == n - 1);
            if ((m % 2) == 0) begin
                mosi      = mo[b];
                tick(HALF);
                sclk_v[m] = ~cpol;
                mi[b]     = miso_v[m];
                wait_sample(last);
                sclk_v[m] = cpol;
            end else begin
                sclk_v[m] = ~cpol;
                mosi      = mo[b];
                tick(HALF);
                sclk_v[m] = cpol;
                mi[b]     = miso_v[m];
                wait_sample(last);
            end
        end
        if ((m % 2) == 0) tick(HALF);
    endtask

    initial begin
        logic [7:0] mi;
        int         o0;
        int         f0;

        checks   = 0;
        errors   = 0;
        ovr_cnt  = 0;
        ferr_cnt = 0;
        rst      = 1'b1;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        sclk_v   = 4'b1100;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;

        vecs[0] = '{0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{0, 8'h81, 8'h81, 8'h81, 8'h81};
        vecs[2] = '{1, 8'h81, 8'h81, 8'h81, 8'h81};
        vecs[3] = '{2, 8'h81, 8'h81, 8'h81, 8'h81};
        vecs[4] = '{3, 8'h81, 8'h81, 8'h81, 8'h81};
        vecs[5] = '{1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[6] = '{2, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
        vecs[7] = '{3, 8'h01, 8'h80, 8'h80, 8'h01};

        tick(4);
        rst = 1'b0;
        tick(1);

        // Reset state of every mode.
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("reset_miso_m%0d", m),     32'(miso_v[m]),     32'(0));
            chk($sformatf("reset_miso_oe_m%0d", m),  32'(miso_oe_v[m]),  32'(0));
            chk($sformatf("reset_tx_ready_m%0d", m), 32'(tx_ready_v[m]), 32'(1));
            chk($sformatf("reset_rx_valid_m%0d", m), 32'(rx_valid_v[m]), 32'(0));
            chk($sformatf("reset_rx_data_m%0d", m),  32'(rx_data_v[m]),  32'(0));
            chk($sformatf("reset_busy_m%0d", m),     32'(busy_v[m]),     32'(0));
        end
        tick(4);

        // Single-word frames across all modes.
        for (int k = 0; k < 8; k++) begin
            int m;
            m = vecs[k].mode;
            pop_rx();
            push_tx(vecs[k].tx);
            frame_begin();
            chk($sformatf("vec%0d_miso_oe_on", k), 32'(miso_oe_v[m]), 32'(1));
            chk($sformatf("vec%0d_busy", k),       32'(busy_v[m]),    32'(1));
            spi_bits(m, vecs[k].mo, 8, 1'b0, mi);
            chk($sformatf("vec%0d_rx_valid", k), 32'(rx_valid_v[m]), 32'(1));
            chk($sformatf("vec%0d_rx_data", k),  32'(rx_data_v[m]),  32'(vecs[k].exp_rx));
            chk($sformatf("vec%0d_miso_word", k), 32'(mi),           32'(vecs[k].exp_mi));
            frame_end();
            chk($sformatf("vec%0d_miso_oe_off", k), 32'(miso_oe_v[m]), 32'(0));
        end

        // Back-to-back words with the holding register refilled per word.
        pop_rx();
        push_tx(8'h11);
        frame_begin();
        push_tx(8'h22);
        spi_bits(0, 8'hC1, 8, 1'b0, mi);
        chk("b2b_w1_miso", 32'(mi), 32'h11);
        chk("b2b_w1_rx_valid", 32'(rx_valid_v[0]), 32'(1));
        chk("b2b_w1_rx_data", 32'(rx_data_v[0]), 32'hC1);
        pop_rx();
        push_tx(8'h33);
        spi_bits(0, 8'hC2, 8, 1'b0, mi);
        chk("b2b_w2_miso", 32'(mi), 32'h22);
        chk("b2b_w2_rx_valid", 32'(rx_valid_v[0]), 32'(1));
        chk("b2b_w2_rx_data", 32'(rx_data_v[0]), 32'hC2);
        pop_rx();
        spi_bits(0, 8'hC3, 8, 1'b0, mi);
        chk("b2b_w3_miso", 32'(mi), 32'h33);
        chk("b2b_w3_rx_valid", 32'(rx_valid_v[0]), 32'(1));
        chk("b2b_w3_rx_data", 32'(rx_data_v[0]), 32'hC3);
        pop_rx();
        spi_bits(0, 8'hC4, 8, 1'b0, mi);
        chk("b2b_empty_miso", 32'(mi), 32'h00);
        chk("b2b_w4_rx_data", 32'(rx_data_v[0]), 32'hC4);
        frame_end();
        pop_rx();

        // Overrun: two unread words, then rx_ready on the completion cycle.
        o0 = ovr_cnt;
        frame_begin();
        spi_bits(0, 8'h71, 8, 1'b0, mi);
        chk("ovr_w1_rx_data", 32'(rx_data_v[0]), 32'h71);
        chk("ovr_w1_no_pulse", 32'(ovr_cnt - o0), 32'(0));
        spi_bits(0, 8'h72, 8, 1'b0, mi);
        chk("ovr_w2_rx_data_kept", 32'(rx_data_v[0]), 32'h71);
        chk("ovr_w2_rx_valid", 32'(rx_valid_v[0]), 32'(1));
        chk("ovr_w2_pulse_once", 32'(ovr_cnt - o0), 32'(1));
        spi_bits(0, 8'h73, 8, 1'b1, mi);
        chk("ovr_w3_rx_data", 32'(rx_data_v[0]), 32'h73);
        chk("ovr_w3_rx_valid", 32'(rx_valid_v[0]), 32'(1));
        chk("ovr_w3_no_new_pulse", 32'(ovr_cnt - o0), 32'(1));
        frame_end();
        pop_rx();

        // Frame error after 5 bits, then a clean frame.
        f0 = ferr_cnt;
        frame_begin();
        spi_bits(0, 8'hFF, 5, 1'b0, mi);
        frame_end();
        chk("ferr_pulse", 32'(ferr_cnt - f0), 32'(1));
        chk("ferr_no_rx_valid", 32'(rx_valid_v[0]), 32'(0));
        chk("ferr_busy_off", 32'(busy_v[0]), 32'(0));
        frame_begin();
        spi_bits(0, 8'h5A, 8, 1'b0, mi);
        frame_end();
        chk("ferr_next_rx_valid", 32'(rx_valid_v[0]), 32'(1));
        chk("ferr_next_rx_data", 32'(rx_data_v[0]), 32'h5A);
        chk("ferr_clean_end", 32'(ferr_cnt - f0), 32'(1));
        pop_rx();

        // Reset in the middle of a frame.
        frame_begin();
        push_tx(8'h96);
        chk("rstmid_tx_ready_low", 32'(tx_ready_v[0]), 32'(0));
        spi_bits(0, 8'hC3, 3, 1'b0, mi);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rstmid_miso", 32'(miso_v[0]), 32'(0));
        chk("rstmid_miso_oe", 32'(miso_oe_v[0]), 32'(0));
        chk("rstmid_busy", 32'(busy_v[0]), 32'(0));
        chk("rstmid_tx_ready", 32'(tx_ready_v[0]), 32'(1));
        chk("rstmid_rx_data", 32'(rx_data_v[0]), 32'(0));
        f0 = ferr_cnt;
        spi_bits(0, 8'hFF, 8, 1'b0, mi);
        chk("rstmid_ignored_busy", 32'(busy_v[0]), 32'(0));
        chk("rstmid_ignored_rx_valid", 32'(rx_valid_v[0]), 32'(0));
        frame_end();
        chk("rstmid_no_ferr", 32'(ferr_cnt - f0), 32'(0));
        frame_begin();
        spi_bits(0, 8'hE7, 8, 1'b0, mi);
        chk("rstmid_next_rx_valid", 32'(rx_valid_v[0]), 32'(1));
        chk("rstmid_next_rx_data", 32'(rx_data_v[0]), 32'hE7);
        chk("rstmid_next_miso", 32'(mi), 32'h00);
        frame_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
